// File: rtl/ads8681_avg_fifo.sv
// Boxcar-averaging decimator for ADS8681 samples feeding a first-word-fall-through output FIFO.
// Averages that arrive while the FIFO is full are dropped and flagged on a sticky Overflow.
module ads8681_avg_fifo #(
    parameter int unsigned BITS       = 16,
    parameter int unsigned LOG2_AVG   = 4,
    parameter bit          SIGNED     = 1'b0,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          Rst,
    input  logic                          InEn,
    input  logic [BITS-1:0]               InData,
    input  logic                          Clear,
    output logic [BITS-1:0]               OutData,
    output logic                          OutValid,
    input  logic                          OutReady,
    output logic [$clog2(FIFO_DEPTH):0]   Level,
    output logic                          Overflow
);

    localparam int unsigned AW = BITS + LOG2_AVG;
    localparam int unsigned CW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_AVG) - 1);
    localparam logic [PW:0]   LVL_FULL = (PW + 1)'(FIFO_DEPTH);

    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   ext;
    logic [AW-1:0]   sum;
    logic [CW-1:0]   cnt_q;
    logic [BITS-1:0] avg;
    logic            last;
    logic            push;
    logic            pop;
    logic            full;
    logic            accept;
    logic            flush;

    logic [BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [PW:0]     level_q;
    logic            overflow_q;

    always_comb begin
        if (SIGNED) begin
            ext = AW'($signed(InData));
        end else begin
            ext = AW'(InData);
        end
        sum  = (cnt_q == '0) ? ext : acc_q + ext;
        // The accumulator is exactly BITS+LOG2_AVG wide, so the low BITS of the shifted sum are
        // this slice for both the logical and arithmetic shift (floor toward -inf).
        avg  = sum[LOG2_AVG +: BITS];
        last = (cnt_q == CNT_LAST);
    end

    assign flush    = Rst | Clear;
    assign OutValid = (level_q != '0);
    assign full     = (level_q == LVL_FULL);
    assign pop      = OutValid & OutReady;
    assign push     = InEn & last;
    assign accept   = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (flush) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (InEn) begin
                acc_q <= sum;
                cnt_q <= last ? '0 : cnt_q + 1'b1;
            end
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (accept && !pop) begin
                level_q <= level_q + 1'b1;
            end else if (pop && !accept) begin
                level_q <= level_q - 1'b1;
            end
            if (push && full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !flush) begin
            mem[wr_ptr_q] <= avg;
        end
    end

    assign OutData  = OutValid ? mem[rd_ptr_q] : '0;
    assign Level    = level_q;
    assign Overflow = overflow_q;

endmodule
